// File: rtl/jtag_tap_sync.sv
// ============================================================================
//  Module      : jtag_tap_sync
//  Description : IEEE 1149.1 TAP controller oversampled by a fast system
//                clock. TCK/TMS/TDI/TRSTn are synchronised into the clock
//                domain and TCK edges are detected from the synced copy.
//                Instructions: IDCODE (5'h01), USERDATA (5'h10, optional),
//                everything else BYPASS.
//  Options     : `define JTAG_TAP_USERDATA_EN enables the USERDATA scan
//                register; without it 5'h10 decodes as BYPASS and
//                update_data/update_valid are tied low.
//  Ports       : clock, reset            - system clock, sync active-high reset
//                jtag_TCK/TMS/TDI/TRSTn  - raw asynchronous JTAG pins
//                jtag_TDO_data/_driven   - TDO value and its output enable
//                capture_data            - word captured in Capture-DR (USERDATA)
//                update_data/update_valid- USERDATA result and 1-clock strobe
//                tap_state               - current TAP state (1149.1 encoding)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tap_sync #(
   parameter logic [31:0] IDCODE   = 32'h1000_0001,
   parameter int          IR_WIDTH = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        jtag_TCK,
   input  logic        jtag_TMS,
   input  logic        jtag_TDI,
   input  logic        jtag_TRSTn,
   output logic        jtag_TDO_data,
   output logic        jtag_TDO_driven,
   input  logic [31:0] capture_data,
   output logic [31:0] update_data,
   output logic        update_valid,
   output logic [3:0]  tap_state
);

   typedef enum logic [3:0] {
      S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PSDR  = 4'h3,
      S_SELIR = 4'h4, S_UPDR  = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
      S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PSIR  = 4'hB,
      S_RTI   = 4'hC, S_UPIR  = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF
   } tap_state_e;

   localparam logic [IR_WIDTH-1:0] c_IR_IDCODE  = IR_WIDTH'(5'h01);
   localparam logic [IR_WIDTH-1:0] c_IR_USER    = IR_WIDTH'(5'h10);
   localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

   // Synchronisers; r_tck_s3 is the delayed copy used for edge detection.
   logic r_tck_s1, r_tck_s2, r_tck_s3;
   logic r_tms_s1, r_tms_s2;
   logic r_tdi_s1, r_tdi_s2;
   logic r_trstn_s1, r_trstn_s2;

   always_ff @(posedge clock) begin
      if (reset) begin
         {r_tck_s1, r_tck_s2, r_tck_s3} <= 3'b000;
         {r_tms_s1, r_tms_s2}           <= 2'b00;
         {r_tdi_s1, r_tdi_s2}           <= 2'b00;
         {r_trstn_s1, r_trstn_s2}       <= 2'b11;
      end else begin
         {r_tck_s1, r_tck_s2, r_tck_s3} <= {jtag_TCK, r_tck_s1, r_tck_s2};
         {r_tms_s1, r_tms_s2}           <= {jtag_TMS, r_tms_s1};
         {r_tdi_s1, r_tdi_s2}           <= {jtag_TDI, r_tdi_s1};
         {r_trstn_s1, r_trstn_s2}       <= {jtag_TRSTn, r_trstn_s1};
      end
   end

   logic w_tck_rise, w_tck_fall, w_trst;
   assign w_tck_rise = r_tck_s2 & ~r_tck_s3;
   assign w_tck_fall = ~r_tck_s2 & r_tck_s3;
   assign w_trst     = ~r_trstn_s2;

   // TAP state machine
   tap_state_e r_state, w_state_next;

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_TLR;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_trst) begin
         w_state_next = S_TLR;
      end else if (w_tck_rise) begin
         case (r_state)
            S_TLR:   w_state_next = r_tms_s2 ? S_TLR   : S_RTI;
            S_RTI:   w_state_next = r_tms_s2 ? S_SELDR : S_RTI;
            S_SELDR: w_state_next = r_tms_s2 ? S_SELIR : S_CAPDR;
            S_CAPDR: w_state_next = r_tms_s2 ? S_EX1DR : S_SHDR;
            S_SHDR:  w_state_next = r_tms_s2 ? S_EX1DR : S_SHDR;
            S_EX1DR: w_state_next = r_tms_s2 ? S_UPDR  : S_PSDR;
            S_PSDR:  w_state_next = r_tms_s2 ? S_EX2DR : S_PSDR;
            S_EX2DR: w_state_next = r_tms_s2 ? S_UPDR  : S_SHDR;
            S_UPDR:  w_state_next = r_tms_s2 ? S_SELDR : S_RTI;
            S_SELIR: w_state_next = r_tms_s2 ? S_TLR   : S_CAPIR;
            S_CAPIR: w_state_next = r_tms_s2 ? S_EX1IR : S_SHIR;
            S_SHIR:  w_state_next = r_tms_s2 ? S_EX1IR : S_SHIR;
            S_EX1IR: w_state_next = r_tms_s2 ? S_UPIR  : S_PSIR;
            S_PSIR:  w_state_next = r_tms_s2 ? S_EX2IR : S_PSIR;
            S_EX2IR: w_state_next = r_tms_s2 ? S_UPIR  : S_SHIR;
            S_UPIR:  w_state_next = r_tms_s2 ? S_SELDR : S_RTI;
            default: w_state_next = S_TLR;
         endcase
      end
   end

   assign tap_state = r_state;

   // Instruction decode and TDO source selection
   logic [IR_WIDTH-1:0] r_ir, r_ir_shift;
   logic [31:0]         r_dr_shift;
   logic                r_bypass;
   logic                r_tdo, r_tdo_driven;
   logic                w_sel_idcode, w_sel_user, w_sel_dr32, w_ir_side, w_tdo_bit;

   assign w_sel_idcode = (r_ir == c_IR_IDCODE);
   assign w_sel_dr32   = w_sel_idcode | w_sel_user;
   // States in the IR column present the IR shift register on TDO.
   assign w_ir_side    = (r_state == S_CAPIR) || (r_state == S_SHIR) ||
                         (r_state == S_EX1IR) || (r_state == S_PSIR) ||
                         (r_state == S_EX2IR) || (r_state == S_UPIR);
   assign w_tdo_bit    = w_ir_side  ? r_ir_shift[0] :
                         w_sel_dr32 ? r_dr_shift[0] : r_bypass;

   // Capture/shift act on TCK rise; update and TDO launch act on TCK fall.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ir         <= c_IR_IDCODE;
         r_ir_shift   <= '0;
         r_dr_shift   <= '0;
         r_bypass     <= 1'b0;
         r_tdo        <= 1'b0;
         r_tdo_driven <= 1'b0;
      end else if (w_trst) begin
         r_ir         <= c_IR_IDCODE;
         r_tdo_driven <= 1'b0;
      end else begin
         if (w_tck_rise) begin
            case (r_state)
               S_CAPIR: r_ir_shift <= c_IR_CAPTURE;
               S_SHIR:  r_ir_shift <= {r_tdi_s2, r_ir_shift[IR_WIDTH-1:1]};
               S_CAPDR: begin
                  if (w_sel_idcode)    r_dr_shift <= IDCODE;
                  else if (w_sel_user) r_dr_shift <= capture_data;
                  else                 r_bypass   <= 1'b0;
               end
               S_SHDR: begin
                  if (w_sel_dr32) r_dr_shift <= {r_tdi_s2, r_dr_shift[31:1]};
                  else            r_bypass   <= r_tdi_s2;
               end
               default: ;
            endcase
            if (w_state_next == S_TLR) r_ir <= c_IR_IDCODE;
         end
         if (w_tck_fall) begin
            r_tdo        <= w_tdo_bit;
            r_tdo_driven <= (r_state == S_SHIR) || (r_state == S_SHDR);
            if (r_state == S_UPIR) r_ir <= r_ir_shift;
         end
      end
   end

   assign jtag_TDO_data   = r_tdo;
   assign jtag_TDO_driven = r_tdo_driven;

`ifdef JTAG_TAP_USERDATA_EN
   logic [31:0] r_update_data;
   logic        r_update_valid;

   assign w_sel_user = (r_ir == c_IR_USER);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_update_data  <= '0;
         r_update_valid <= 1'b0;
      end else begin
         r_update_valid <= 1'b0;
         if (!w_trst && w_tck_fall && (r_state == S_UPDR) && w_sel_user) begin
            r_update_data  <= r_dr_shift;
            r_update_valid <= 1'b1;
         end
      end
   end

   assign update_data  = r_update_data;
   assign update_valid = r_update_valid;
`else
   assign w_sel_user   = 1'b0;
   assign update_data  = '0;
   assign update_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_sync.sv
`default_nettype none

module tb_jtag_tap_sync;

   localparam int          PH = 6;              // clocks per TCK phase
   localparam logic [31:0] ID = 32'h1000_0001;
`ifdef JTAG_TAP_USERDATA_EN
   localparam bit USER_EN = 1'b1;
`else
   localparam bit USER_EN = 1'b0;
`endif

   logic        clock = 1'b0, reset = 1'b1;
   logic        jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
   logic [31:0] capture_data = '0;
   logic        jtag_TDO_data, jtag_TDO_driven, update_valid;
   logic [31:0] update_data;
   logic [3:0]  tap_state;

   int checks = 0, failures = 0, obs_pulses = 0;

   jtag_tap_sync dut (
      .clock(clock), .reset(reset),
      .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
      .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
      .capture_data(capture_data), .update_data(update_data),
      .update_valid(update_valid), .tap_state(tap_state)
   );

   always #5 clock = ~clock;

   // Counts clocks on which update_valid is high (a clean pulse counts once).
   always @(negedge clock) if (update_valid === 1'b1) obs_pulses <= obs_pulses + 1;

   // ---------------- reference model ----------------
   // 1149.1 state graph as lookup tables indexed by state code.
   logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
   logic [3:0]  m_state;
   logic [4:0]  m_ir, m_ir_sh;
   logic [31:0] m_dr, m_upd;
   int          m_len, m_pulses;
   logic        m_tdo, m_drv;

   task automatic model_reset();
      m_state = 4'hF; m_ir = 5'h01; m_ir_sh = '0; m_dr = '0; m_len = 1;
      m_upd = '0; m_tdo = 1'b0; m_drv = 1'b0;
   endtask

   task automatic model_rise(input bit tms, input bit tdi);
      case (m_state)
         4'hE: m_ir_sh = 5'h01;
         4'hA: m_ir_sh = (m_ir_sh >> 1) | (5'(tdi) << 4);
         4'h6: begin
            if (m_ir == 5'h01)                 begin m_dr = ID;           m_len = 32; end
            else if (m_ir == 5'h10 && USER_EN) begin m_dr = capture_data; m_len = 32; end
            else                               begin m_dr = '0;           m_len = 1;  end
         end
         4'h2: m_dr = (m_dr >> 1) | (32'(tdi) << (m_len - 1));
         default: ;
      endcase
      m_state = tms ? NXT1[m_state] : NXT0[m_state];
      if (m_state == 4'hF) m_ir = 5'h01;
   endtask

   task automatic model_fall();
      if (m_state == 4'hD) m_ir = m_ir_sh;
      if (m_state == 4'h5 && m_ir == 5'h10 && USER_EN) begin
         m_upd = m_dr; m_pulses++;
      end
      m_drv = (m_state == 4'h2) || (m_state == 4'hA);
      m_tdo = (m_state inside {4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD}) ? m_ir_sh[0] : m_dr[0];
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tck_cycle(input bit tms, input bit tdi);
      jtag_TMS = tms; jtag_TDI = tdi;
      repeat (PH) @(negedge clock);
      jtag_TCK = 1'b1; model_rise(tms, tdi);
      repeat (PH) @(negedge clock);
      jtag_TCK = 1'b0; model_fall();
      repeat (PH) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1; jtag_TCK = 1'b0;
      repeat (3) @(negedge clock);
      model_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // From TLR or RTI: load an instruction, end in RTI. Returns captured IR bits.
   task automatic scan_ir(input logic [4:0] code, output logic [4:0] cap);
      tck_cycle(0, 0); tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
      for (int i = 0; i < 5; i++) begin cap[i] = jtag_TDO_data; tck_cycle(i == 4, code[i]); end
      tck_cycle(1, 0); tck_cycle(0, 0);
   endtask

   // From TLR or RTI: full 32-bit DR scan through Update-DR, end in RTI.
   task automatic scan_dr(input logic [31:0] din, output logic [31:0] dout);
      tck_cycle(0, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
      for (int i = 0; i < 32; i++) begin dout[i] = jtag_TDO_data; tck_cycle(i == 31, din[i]); end
      tck_cycle(1, 0); tck_cycle(0, 0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL reset_state got=%h exp=F", tap_state); end
      checks++; if (jtag_TDO_driven !== 1'b0) begin failures++; $display("FAIL reset_driven got=%b exp=0", jtag_TDO_driven); end
      checks++; if (jtag_TDO_data !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b exp=0", jtag_TDO_data); end
      checks++; if (update_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", update_valid); end
      checks++; if (update_data !== 32'h0) begin failures++; $display("FAIL reset_upd got=%h exp=0", update_data); end
      do_reset();
   endtask

   task automatic test_idcode();
      logic [31:0] dout;
      do_reset();
      scan_dr(32'h0, dout);
      checks++; if (dout !== ID) begin failures++; $display("FAIL idcode_stream got=%h exp=%h", dout, ID); end
      checks++; if (tap_state !== 4'hC) begin failures++; $display("FAIL idcode_end_state got=%h exp=C", tap_state); end
   endtask

   task automatic test_tlr_reset();
      logic [31:0] dout;
      for (int i = 0; i < 25; i++) tck_cycle($urandom_range(0, 1), $urandom_range(0, 1));
      for (int i = 0; i < 5; i++) tck_cycle(1, 0);
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL tlr_state got=%h exp=F", tap_state); end
      scan_dr(32'h0, dout);
      checks++; if (dout !== ID) begin failures++; $display("FAIL tlr_ir_idcode got=%h exp=%h", dout, ID); end
   endtask

   task automatic test_bypass();
      logic [4:0] cap;
      logic [3:0] obs;
      logic [3:0] pat = 4'b1101;   // TDI 1,0,1,1 in shift order
      scan_ir(5'h1F, cap);
      checks++; if (cap !== 5'b00001) begin failures++; $display("FAIL ir_capture got=%b exp=00001", cap); end
      tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
      checks++; if (jtag_TDO_driven !== 1'b1) begin failures++; $display("FAIL bypass_driven got=%b exp=1", jtag_TDO_driven); end
      for (int i = 0; i < 4; i++) begin obs[i] = jtag_TDO_data; tck_cycle(i == 3, pat[i]); end
      checks++; if (obs !== 4'b1010) begin failures++; $display("FAIL bypass_tdo got=%b exp=1010", obs); end
      checks++; if (jtag_TDO_driven !== 1'b0) begin failures++; $display("FAIL bypass_exit_driven got=%b exp=0", jtag_TDO_driven); end
      tck_cycle(1, 0); tck_cycle(0, 0);
   endtask

   task automatic test_userdata();
      logic [4:0]  cap;
      logic [31:0] dout;
      int          p0;
      scan_ir(5'h10, cap);
      capture_data = 32'hDEADBEEF;
      p0 = obs_pulses;
      scan_dr(32'h12345678, dout);
      checks++; if (dout !== (USER_EN ? 32'hDEADBEEF : 32'h2468ACF0)) begin
         failures++; $display("FAIL user_stream got=%h exp=%h", dout, USER_EN ? 32'hDEADBEEF : 32'h2468ACF0); end
      checks++; if (update_data !== (USER_EN ? 32'h12345678 : 32'h0)) begin
         failures++; $display("FAIL user_update_data got=%h exp=%h", update_data, USER_EN ? 32'h12345678 : 32'h0); end
      checks++; if (obs_pulses - p0 !== (USER_EN ? 1 : 0)) begin
         failures++; $display("FAIL user_pulse_clocks got=%0d exp=%0d", obs_pulses - p0, USER_EN ? 1 : 0); end
   endtask

   task automatic test_trst();
      logic [4:0]  cap;
      logic [31:0] dout;
      int          p0;
      scan_ir(5'h10, cap);
      tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
      for (int i = 0; i < 3; i++) tck_cycle(0, 1);
      p0 = obs_pulses;
      jtag_TRSTn = 1'b0;
      repeat (4) @(negedge clock);
      jtag_TRSTn = 1'b1;
      m_state = 4'hF; m_ir = 5'h01; m_drv = 1'b0;
      repeat (6) @(negedge clock);
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL trst_state got=%h exp=F", tap_state); end
      checks++; if (jtag_TDO_driven !== 1'b0) begin failures++; $display("FAIL trst_driven got=%b exp=0", jtag_TDO_driven); end
      checks++; if (obs_pulses !== p0) begin failures++; $display("FAIL trst_pulse got=%0d exp=%0d", obs_pulses - p0, 0); end
      scan_dr(32'h0, dout);
      checks++; if (dout !== ID) begin failures++; $display("FAIL trst_ir_idcode got=%h exp=%h", dout, ID); end
   endtask

   task automatic test_reset_midscan();
      logic [4:0] cap;
      int         p0;
      scan_ir(5'h10, cap);
      capture_data = $urandom;
      tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
      for (int i = 0; i < 8; i++) tck_cycle(0, $urandom_range(0, 1));
      p0 = obs_pulses;
      do_reset();
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL midrst_state got=%h exp=F", tap_state); end
      checks++; if (update_data !== 32'h0) begin failures++; $display("FAIL midrst_upd got=%h exp=0", update_data); end
      checks++; if (jtag_TDO_driven !== 1'b0) begin failures++; $display("FAIL midrst_driven got=%b exp=0", jtag_TDO_driven); end
      for (int i = 0; i < 3; i++) tck_cycle(1, 0);
      checks++; if (obs_pulses !== p0) begin failures++; $display("FAIL midrst_pulse got=%0d exp=0", obs_pulses - p0); end
   endtask

   task automatic test_random();
      do_reset();
      m_pulses = obs_pulses;
      for (int n = 0; n < 300; n++) begin
         capture_data = $urandom;
         tck_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1));
         checks++; if (tap_state !== m_state) begin
            failures++; $display("FAIL rand_state n=%0d got=%h exp=%h", n, tap_state, m_state); end
         checks++; if (jtag_TDO_driven !== m_drv) begin
            failures++; $display("FAIL rand_driven n=%0d got=%b exp=%b", n, jtag_TDO_driven, m_drv); end
         if (m_drv) begin
            checks++; if (jtag_TDO_data !== m_tdo) begin
               failures++; $display("FAIL rand_tdo n=%0d got=%b exp=%b", n, jtag_TDO_data, m_tdo); end
         end
      end
      checks++; if (obs_pulses !== m_pulses) begin
         failures++; $display("FAIL rand_pulses got=%0d exp=%0d", obs_pulses, m_pulses); end
      checks++; if (update_data !== m_upd) begin
         failures++; $display("FAIL rand_update_data got=%h exp=%h", update_data, m_upd); end
   endtask

   initial begin
      model_reset();
      m_pulses = 0;
      test_reset();
      test_idcode();
      test_tlr_reset();
      test_bypass();
      test_userdata();
      test_trst();
      test_reset_midscan();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/jtag_tap_sync.md
JTAG_TAP_SYNC -- requirements
Module: jtag_tap_sync

Interface
REQ-001 Parameter IDCODE, default 32'h1000_0001: value loaded in Capture-DR under IDCODE; bit0 SHALL be 1.
REQ-002 Parameter IR_WIDTH, default 5: instruction register width.
REQ-003 clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 jtag_TCK  input  1  asynchronous test clock.
REQ-006 jtag_TMS  input  1  asynchronous test mode select.
REQ-007 jtag_TDI  input  1  asynchronous test data in.
REQ-008 jtag_TRSTn  input  1  asynchronous test reset, active-low.
REQ-009 jtag_TDO_data  output  1  test data out.
REQ-010 jtag_TDO_driven  output  1  high while TDO is valid (Shift-IR/Shift-DR).
REQ-011 capture_data  input  32  word captured into the USERDATA scan register.
REQ-012 update_data  output  32  USERDATA scan register contents at Update-DR.
REQ-013 update_valid  output  1  one-clock pulse when update_data is written.
REQ-014 tap_state  output  4  current TAP state, IEEE 1149.1 encoding (TLR=4'hF, RTI=4'hC, ShiftDR=4'h2, ShiftIR=4'hA, etc.).

Function
REQ-015 TCK, TMS, TDI, TRSTn SHALL each pass a 2-flop synchronizer; TCK edges SHALL be detected against a third registered copy of synced TCK.
REQ-016 Rising-edge detection SHALL be 3 clocks after the raw TCK rise; the input TCK high and low phases SHALL each be at least 4 clocks.
REQ-017 On each detected TCK rise, the FSM SHALL advance one state per the 16-state IEEE 1149.1 graph using synced TMS.
REQ-018 Synced TRSTn low SHALL force Test-Logic-Reset and IR=IDCODE; it SHALL override a simultaneous TCK rise.
REQ-019 Entering Test-Logic-Reset by any path SHALL load IR with IDCODE (5'h01).
REQ-020 Capture-IR: IR shift register SHALL load {0..0,2'b01}.
REQ-021 Shift-IR/Shift-DR: on each TCK rise, the selected register SHALL shift right with synced TDI into its MSB.
REQ-022 Update-IR: IR SHALL latch the IR shift register.
REQ-023 Instructions: IDCODE=5'h01 (32-bit), USERDATA=5'h10 (32-bit), all other codes BYPASS (1-bit).
REQ-024 Capture-DR SHALL load IDCODE, capture_data, or 0 according to IR.
REQ-025 Update-DR with IR=USERDATA SHALL set update_data to the shift register and pulse update_valid for exactly one clock.
REQ-026 On each detected TCK fall, jtag_TDO_data SHALL take the selected register's LSB, and jtag_TDO_driven SHALL be 1 iff the state is Shift-IR or Shift-DR, else 0.
REQ-027 tap_state SHALL be registered and SHALL change on the clock after the detected TCK rise.

Reset
REQ-028 reset SHALL set: state=TLR, IR=5'h01, shift registers=0, jtag_TDO_data=0, jtag_TDO_driven=0, update_data=0, update_valid=0, synchronizers=0 (TRSTn sync=1).
REQ-029 reset asserted mid-scan SHALL abandon the scan with no update_valid pulse.

Configuration
REQ-030 With macro JTAG_TAP_USERDATA_EN defined, USERDATA SHALL behave per REQ-023..025.
REQ-031 Without it, 5'h10 SHALL decode as BYPASS, and update_data/update_valid SHALL be tied 0.

Verification
REQ-032 Five TCK cycles with TMS=1 from any state -> tap_state=4'hF, IR=5'h01.
REQ-033 TLR->Shift-DR, 32 TCK with TDI=0 -> TDO serial stream LSB-first = 32'h1000_0001 (default IDCODE).
REQ-034 IR<=5'h1F, Shift-DR with TDI pattern 1,0,1,1 -> TDO=0,1,0,1 (one-cycle bypass delay).
REQ-035 IR<=5'h10, capture_data=32'hDEADBEEF, shift in 32'h12345678 -> TDO stream=32'hDEADBEEF; at Update-DR, update_data=32'h12345678 and update_valid high for one clock.
REQ-036 TRSTn driven low for 4 clocks during Shift-DR -> tap_state=4'hF, jtag_TDO_driven=0, no update_valid.
REQ-037 Build without JTAG_TAP_USERDATA_EN, IR<=5'h10 -> single-bit bypass, update_valid stays 0.
